// File: rtl/sudoku_game_ctrl_if.sv
// Purpose: user/datapath signal bundle for the sudoku game controller.
// Latency: n/a (wires only).
// Backpressure: none; all commands are level inputs sampled by the controller.
interface sudoku_game_ctrl_if;
  // user side
  logic        start;
  logic [1:0]  difficulty_sel;
  logic [3:0]  cell_sel;
  logic [1:0]  val;
  logic        enter;
  logic        check;
  // datapath results
  logic [15:0] fill_flag;
  logic        solved;
  // controller outputs
  logic        set_board;
  logic [1:0]  difficulty;
  logic        register_inp_flag;
  logic [3:0]  reg_choose;
  logic [1:0]  value_inp;
  logic        dp_check;
  logic        won;
  logic        try_again_flag;
  logic [3:0]  ridx_a;
  logic [3:0]  ridx_b;
  logic [2:0]  state;
  logic [1:0]  attempts;
  logic        rejected;

  // controller view
  modport master (
    input  start, difficulty_sel, cell_sel, val, enter, check, fill_flag, solved,
    output set_board, difficulty, register_inp_flag, reg_choose, value_inp,
           dp_check, won, try_again_flag, ridx_a, ridx_b, state, attempts, rejected
  );

  // user/datapath view
  modport slave (
    output start, difficulty_sel, cell_sel, val, enter, check, fill_flag, solved,
    input  set_board, difficulty, register_inp_flag, reg_choose, value_inp,
           dp_check, won, try_again_flag, ridx_a, ridx_b, state, attempts, rejected
  );
endinterface

// File: rtl/sudoku_game_ctrl.sv
// Purpose: game FSM for a 4x4 sudoku: load, cell writes, board check, win/lose.
// Latency: user edges act 2 cycles after the level rises; all outputs registered.
// Backpressure: none; commands outside their legal state are dropped.
// Option: define SUDOKU_TRY_LIMIT_EN to end the game (LOST) on the third failed check.
module sudoku_game_ctrl (
  input  logic clka,
  input  logic restart,
  sudoku_game_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PLAY  = 3'd2,
    WRITE = 3'd3,
    CHECK = 3'd4,
    WAIT  = 3'd5,
    WON   = 3'd6,
    LOST  = 3'd7
  } state_t;

  state_t      cur;
  logic        start_r, start_p;
  logic        enter_r, enter_p;
  logic        check_r, check_p;
  logic        start_ev, enter_ev, check_ev;
  logic        wait_cnt;
  logic        set_board_q, register_inp_flag_q, dp_check_q, try_again_q, rejected_q;
  logic        won_q;
  logic [1:0]  difficulty_q;
  logic [1:0]  attempts_q;
  logic [1:0]  attempts_inc;
  logic [3:0]  reg_choose_q;
  logic [1:0]  value_inp_q;
  logic [3:0]  ridx_a_q, ridx_b_q;

  assign start_ev = start_r & ~start_p;
  assign enter_ev = enter_r & ~enter_p;
  assign check_ev = check_r & ~check_p;
  assign attempts_inc = (attempts_q == 2'd3) ? 2'd3 : attempts_q + 2'd1;

  // Register each user level once and keep the previous sample for edge detection.
  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      start_r <= 1'b0; start_p <= 1'b0;
      enter_r <= 1'b0; enter_p <= 1'b0;
      check_r <= 1'b0; check_p <= 1'b0;
    end else begin
      start_r <= bus.start; start_p <= start_r;
      enter_r <= bus.enter; enter_p <= enter_r;
      check_r <= bus.check; check_p <= check_r;
    end
  end

  // Datapath read indices: A follows the user cursor, B scans the display.
  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      ridx_a_q <= 4'd0;
      ridx_b_q <= 4'd0;
    end else begin
      ridx_a_q <= bus.cell_sel;
      ridx_b_q <= ridx_b_q + 4'd1;
    end
  end

  // Game FSM; strobes default low each cycle so none can stretch past one cycle.
  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      cur                 <= IDLE;
      wait_cnt            <= 1'b0;
      set_board_q         <= 1'b0;
      register_inp_flag_q <= 1'b0;
      dp_check_q          <= 1'b0;
      try_again_q         <= 1'b0;
      rejected_q          <= 1'b0;
      won_q               <= 1'b0;
      difficulty_q        <= 2'd0;
      attempts_q          <= 2'd0;
      reg_choose_q        <= 4'd0;
      value_inp_q         <= 2'd0;
    end else begin
      set_board_q         <= 1'b0;
      register_inp_flag_q <= 1'b0;
      dp_check_q          <= 1'b0;
      try_again_q         <= 1'b0;
      rejected_q          <= 1'b0;
      unique case (cur)
        IDLE, WON, LOST: begin
          // LOST is only entered when the try limit is compiled in.
          if (start_ev) begin
            difficulty_q <= bus.difficulty_sel;
            attempts_q   <= 2'd0;
            won_q        <= 1'b0;
            set_board_q  <= 1'b1;
            cur          <= LOAD;
          end
        end
        LOAD: begin
          cur <= PLAY;
        end
        PLAY: begin
          // A simultaneous enter is dropped in favour of the check.
          if (check_ev) begin
            dp_check_q <= 1'b1;
            cur        <= CHECK;
          end else if (enter_ev) begin
            reg_choose_q <= bus.cell_sel;
            value_inp_q  <= bus.val;
            cur          <= WRITE;
          end
        end
        WRITE: begin
          // Given cells are protected: refuse the write instead of strobing it.
          if (bus.fill_flag[reg_choose_q]) rejected_q <= 1'b1;
          else                             register_inp_flag_q <= 1'b1;
          cur <= PLAY;
        end
        CHECK: begin
          wait_cnt <= 1'b0;
          cur      <= WAIT;
        end
        WAIT: begin
          // Two cycles for the datapath to settle its solved result.
          if (!wait_cnt) begin
            wait_cnt <= 1'b1;
          end else if (bus.solved) begin
            won_q <= 1'b1;
            cur   <= WON;
          end else begin
            try_again_q <= 1'b1;
            attempts_q  <= attempts_inc;
`ifdef SUDOKU_TRY_LIMIT_EN
            if (attempts_inc == 2'd3) cur <= LOST;
            else                      cur <= PLAY;
`else
            cur <= PLAY;
`endif
          end
        end
        default: cur <= IDLE;
      endcase
    end
  end

  assign bus.set_board         = set_board_q;
  assign bus.difficulty        = difficulty_q;
  assign bus.register_inp_flag = register_inp_flag_q;
  assign bus.reg_choose        = reg_choose_q;
  assign bus.value_inp         = value_inp_q;
  assign bus.dp_check          = dp_check_q;
  assign bus.won               = won_q;
  assign bus.try_again_flag    = try_again_q;
  assign bus.ridx_a            = ridx_a_q;
  assign bus.ridx_b            = ridx_b_q;
  assign bus.state             = cur;
  assign bus.attempts          = attempts_q;
  assign bus.rejected          = rejected_q;

endmodule

// File: tb/tb_sudoku_game_ctrl.sv
// Bench for sudoku_game_ctrl: directed scenarios with a strobe scoreboard.
// Strobe kinds: 0 set_board, 1 register_inp_flag, 2 rejected, 3 dp_check, 4 try_again_flag.
module tb_sudoku_game_ctrl;

  logic clka;
  logic restart;
  sudoku_game_ctrl_if bus ();

  sudoku_game_ctrl dut (
    .clka    (clka),
    .restart (restart),
    .bus     (bus.master)
  );

  typedef struct {
    int        kind;
    logic [5:0] data;
  } ev_t;

  ev_t exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  logic [4:0] obs;
  logic [4:0] prev_obs = 5'd0;
  logic [5:0] od;
  ev_t e;

  initial clka = 1'b0;
  always #5 clka = ~clka;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every strobe must match the next expected event, and none may be 2 cycles wide.
  always @(negedge clka) begin
    obs = {bus.try_again_flag, bus.dp_check, bus.rejected, bus.register_inp_flag, bus.set_board};
    if ((obs & prev_obs) != 5'd0) begin
      n_assert++;
      n_fail++;
      $display("FAIL strobe_width: strobes %b high two cycles running", obs & prev_obs);
    end
    prev_obs = obs;
    for (int k = 0; k < 5; k++) begin
      if (obs[k]) begin
        n_assert++;
        case (k)
          0:       od = {4'd0, bus.difficulty};
          1, 2:    od = {bus.reg_choose, bus.value_inp};
          4:       od = {4'd0, bus.attempts};
          default: od = 6'd0;
        endcase
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL strobe_unexpected: got kind=%0d data=%0h, expected none", k, od);
        end else begin
          e = exp_q.pop_front();
          if (e.kind !== k || e.data !== od) begin
            n_fail++;
            $display("FAIL strobe_match: got kind=%0d data=%0h, expected kind=%0d data=%0h",
                     k, od, e.kind, e.data);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clka);
    #1;
  endtask

  task automatic push(input int kind, input logic [5:0] data);
    ev_t x;
    x.kind = kind;
    x.data = data;
    exp_q.push_back(x);
  endtask

  task automatic test_reset;
    restart = 1'b1;
    bus.start = 0; bus.difficulty_sel = 0; bus.cell_sel = 0; bus.val = 0;
    bus.enter = 0; bus.check = 0; bus.fill_flag = 16'h0; bus.solved = 0;
    step(3);
    n_assert++;
    if (bus.state !== 3'd0 || bus.won !== 1'b0 || bus.attempts !== 2'd0 ||
        bus.difficulty !== 2'd0 || bus.reg_choose !== 4'd0 || bus.value_inp !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_regs: state=%0d won=%0d att=%0d diff=%0d rc=%0d vi=%0d, expected all 0",
               bus.state, bus.won, bus.attempts, bus.difficulty, bus.reg_choose, bus.value_inp);
    end
    n_assert++;
    if (bus.ridx_a !== 4'd0 || bus.ridx_b !== 4'd0 || bus.set_board !== 1'b0 ||
        bus.register_inp_flag !== 1'b0 || bus.dp_check !== 1'b0 ||
        bus.try_again_flag !== 1'b0 || bus.rejected !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs: ridx_a=%0d ridx_b=%0d strobes=%b, expected all 0",
               bus.ridx_a, bus.ridx_b,
               {bus.set_board, bus.register_inp_flag, bus.dp_check, bus.try_again_flag, bus.rejected});
    end
    restart = 1'b0;
    step(1);
  endtask

  task automatic test_ridx;
    logic [3:0] b0;
    int guard;
    bus.cell_sel = 4'd9;
    step(1);
    n_assert++;
    if (bus.ridx_a !== 4'd9) begin
      n_fail++; $display("FAIL ridx_a: got %0d, expected 9", bus.ridx_a);
    end
    bus.cell_sel = 4'd0;
    b0 = bus.ridx_b;
    step(1);
    n_assert++;
    if (bus.ridx_b !== b0 + 4'd1) begin
      n_fail++; $display("FAIL ridx_b_inc: got %0d, expected %0d", bus.ridx_b, b0 + 4'd1);
    end
    guard = 0;
    while (bus.ridx_b !== 4'd15 && guard < 20) begin
      step(1);
      guard++;
    end
    step(1);
    n_assert++;
    if (bus.ridx_b !== 4'd0) begin
      n_fail++; $display("FAIL ridx_b_wrap: got %0d, expected 0", bus.ridx_b);
    end
  endtask

  task automatic test_start;
    bus.difficulty_sel = 2'd2;
    bus.start = 1'b1;
    push(0, 6'd2);
    step(1);
    n_assert++;
    if (bus.state !== 3'd0) begin
      n_fail++; $display("FAIL start_s0: state=%0d, expected 0", bus.state);
    end
    step(1);
    n_assert++;
    if (bus.state !== 3'd1 || bus.set_board !== 1'b1 || bus.difficulty !== 2'd2) begin
      n_fail++;
      $display("FAIL start_load: state=%0d set_board=%0d diff=%0d, expected 1/1/2",
               bus.state, bus.set_board, bus.difficulty);
    end
    step(1);
    n_assert++;
    if (bus.state !== 3'd2 || bus.set_board !== 1'b0) begin
      n_fail++;
      $display("FAIL start_play: state=%0d set_board=%0d, expected 2/0", bus.state, bus.set_board);
    end
    bus.start = 1'b0;
    step(2);
  endtask

  task automatic test_write_ok;
    bus.fill_flag = 16'h0001;
    bus.cell_sel = 4'd5;
    bus.val = 2'd3;
    bus.enter = 1'b1;
    push(1, {4'd5, 2'd3});
    step(2);
    n_assert++;
    if (bus.state !== 3'd3) begin
      n_fail++; $display("FAIL write_state: state=%0d, expected 3", bus.state);
    end
    step(1);
    n_assert++;
    if (bus.state !== 3'd2 || bus.register_inp_flag !== 1'b1 ||
        bus.reg_choose !== 4'd5 || bus.value_inp !== 2'd3) begin
      n_fail++;
      $display("FAIL write_ok: state=%0d wr=%0d rc=%0d vi=%0d, expected 2/1/5/3",
               bus.state, bus.register_inp_flag, bus.reg_choose, bus.value_inp);
    end
    bus.enter = 1'b0;
    step(2);
  endtask

  task automatic test_write_reject;
    bus.fill_flag = 16'h0001;
    bus.cell_sel = 4'd0;
    bus.val = 2'd1;
    bus.enter = 1'b1;
    push(2, {4'd0, 2'd1});
    step(3);
    n_assert++;
    if (bus.state !== 3'd2 || bus.rejected !== 1'b1 || bus.register_inp_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL write_reject: state=%0d rej=%0d wr=%0d, expected 2/1/0",
               bus.state, bus.rejected, bus.register_inp_flag);
    end
    bus.enter = 1'b0;
    step(2);
  endtask

  task automatic test_check_solved;
    bus.solved = 1'b1;
    bus.check = 1'b1;
    push(3, 6'd0);
    step(2);
    n_assert++;
    if (bus.state !== 3'd4 || bus.dp_check !== 1'b1) begin
      n_fail++;
      $display("FAIL check_state: state=%0d dp_check=%0d, expected 4/1", bus.state, bus.dp_check);
    end
    step(1);
    n_assert++;
    if (bus.state !== 3'd5) begin
      n_fail++; $display("FAIL wait_1: state=%0d, expected 5", bus.state);
    end
    step(1);
    n_assert++;
    if (bus.state !== 3'd5) begin
      n_fail++; $display("FAIL wait_2: state=%0d, expected 5", bus.state);
    end
    step(1);
    n_assert++;
    if (bus.state !== 3'd6 || bus.won !== 1'b1) begin
      n_fail++; $display("FAIL won: state=%0d won=%0d, expected 6/1", bus.state, bus.won);
    end
    bus.check = 1'b0;
    step(2);
  endtask

  task automatic test_won_restart;
    bus.enter = 1'b1;
    bus.check = 1'b1;
    step(4);
    n_assert++;
    if (bus.state !== 3'd6 || bus.won !== 1'b1) begin
      n_fail++;
      $display("FAIL won_ignore: state=%0d won=%0d, expected 6/1", bus.state, bus.won);
    end
    bus.enter = 1'b0;
    bus.check = 1'b0;
    step(2);
    bus.difficulty_sel = 2'd1;
    bus.start = 1'b1;
    push(0, 6'd1);
    step(2);
    n_assert++;
    if (bus.state !== 3'd1 || bus.difficulty !== 2'd1 || bus.won !== 1'b0 || bus.attempts !== 2'd0) begin
      n_fail++;
      $display("FAIL won_restart: state=%0d diff=%0d won=%0d att=%0d, expected 1/1/0/0",
               bus.state, bus.difficulty, bus.won, bus.attempts);
    end
    step(1);
    bus.start = 1'b0;
    step(2);
  endtask

  task automatic test_fail_checks;
    logic [2:0] exp_state;
    bus.solved = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      bus.check = 1'b1;
      push(3, 6'd0);
      push(4, 6'(k));
      step(5);
`ifdef SUDOKU_TRY_LIMIT_EN
      exp_state = (k == 3) ? 3'd7 : 3'd2;
`else
      exp_state = 3'd2;
`endif
      n_assert++;
      if (bus.try_again_flag !== 1'b1 || bus.attempts !== 2'(k) || bus.state !== exp_state ||
          bus.won !== 1'b0) begin
        n_fail++;
        $display("FAIL fail_check_%0d: try=%0d att=%0d state=%0d won=%0d, expected 1/%0d/%0d/0",
                 k, bus.try_again_flag, bus.attempts, bus.state, bus.won, k, exp_state);
      end
      bus.check = 1'b0;
      step(2);
    end
`ifdef SUDOKU_TRY_LIMIT_EN
    bus.difficulty_sel = 2'd2;
    bus.start = 1'b1;
    push(0, 6'd2);
    step(3);
    n_assert++;
    if (bus.state !== 3'd2 || bus.attempts !== 2'd0) begin
      n_fail++;
      $display("FAIL lost_restart: state=%0d att=%0d, expected 2/0", bus.state, bus.attempts);
    end
    bus.start = 1'b0;
    step(2);
`else
    bus.check = 1'b1;
    push(3, 6'd0);
    push(4, 6'd3);
    step(5);
    n_assert++;
    if (bus.try_again_flag !== 1'b1 || bus.attempts !== 2'd3 || bus.state !== 3'd2) begin
      n_fail++;
      $display("FAIL attempts_sat: try=%0d att=%0d state=%0d, expected 1/3/2",
               bus.try_again_flag, bus.attempts, bus.state);
    end
    bus.check = 1'b0;
    step(2);
`endif
  endtask

  task automatic test_enter_check_same;
    bus.solved = 1'b1;
    bus.fill_flag = 16'h0000;
    bus.cell_sel = 4'd7;
    bus.val = 2'd2;
    bus.enter = 1'b1;
    bus.check = 1'b1;
    push(3, 6'd0);
    step(2);
    n_assert++;
    if (bus.state !== 3'd4 || bus.reg_choose !== 4'd0) begin
      n_fail++;
      $display("FAIL same_cycle: state=%0d rc=%0d, expected 4/0", bus.state, bus.reg_choose);
    end
    step(3);
    n_assert++;
    if (bus.state !== 3'd6) begin
      n_fail++; $display("FAIL same_cycle_won: state=%0d, expected 6", bus.state);
    end
    bus.enter = 1'b0;
    bus.check = 1'b0;
    step(2);
    bus.difficulty_sel = 2'd3;
    bus.start = 1'b1;
    push(0, 6'd3);
    step(3);
    bus.start = 1'b0;
    step(2);
  endtask

  task automatic test_restart_in_wait;
    bus.solved = 1'b0;
    bus.check = 1'b1;
    push(3, 6'd0);
    step(3);
    n_assert++;
    if (bus.state !== 3'd5) begin
      n_fail++; $display("FAIL pre_abort: state=%0d, expected 5", bus.state);
    end
    restart = 1'b1;
    #1;
    n_assert++;
    if (bus.state !== 3'd0 || bus.attempts !== 2'd0 || bus.difficulty !== 2'd0) begin
      n_fail++;
      $display("FAIL abort_async: state=%0d att=%0d diff=%0d, expected 0/0/0",
               bus.state, bus.attempts, bus.difficulty);
    end
    bus.check = 1'b0;
    step(3);
    restart = 1'b0;
    step(3);
    n_assert++;
    if (bus.state !== 3'd0 || bus.try_again_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_after: state=%0d try=%0d, expected 0/0", bus.state, bus.try_again_flag);
    end
  endtask

  initial begin
    test_reset();
    test_ridx();
    test_start();
    test_write_ok();
    test_write_reject();
    test_check_solved();
    test_won_restart();
    test_fail_checks();
    test_enter_check_same();
    test_restart_in_wait();
    step(2);
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected strobes never seen, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
